// File: rtl/dmem_arbiter.sv
// Two-port (A: CPU, B: loader/debug) arbiter for a single-port data memory: round-robin on ties, bounded lock for atomic sequences.
// Optional per-port grant / conflict counters when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
    parameter int DW       = 32,
    parameter int AW       = 32,
    parameter int LOCK_MAX = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic          a_lock,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    input  logic          b_lock,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]   stat_a_cnt,
    output logic [15:0]   stat_b_cnt,
    output logic [15:0]   stat_conflict_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;

    localparam int CW = $clog2(LOCK_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

    state_t        state;
    logic [CW-1:0] lock_cnt;

    // owner is the last winner, so on a tie the other port goes next.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (reset_n) begin
            case (state)
                IDLE: begin
                    if (a_req && b_req) begin
                        a_gnt = owner;
                        b_gnt = !owner;
                    end else begin
                        a_gnt = a_req;
                        b_gnt = b_req;
                    end
                end
                LOCK_A:  a_gnt = a_req;
                LOCK_B:  b_gnt = b_req;
                default: ;
            endcase
        end
    end

    assign mem_we    = (a_gnt & a_we) | (b_gnt & b_we);
    assign mem_addr  = b_gnt ? b_addr  : a_addr;
    assign mem_wdata = b_gnt ? b_wdata : a_wdata;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            lock_cnt <= '0;
            owner    <= 1'b1;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= a_gnt & ~a_we;
            b_rvalid <= b_gnt & ~b_we;
            if (a_gnt && !a_we) a_rdata <= mem_rdata;
            if (b_gnt && !b_we) b_rdata <= mem_rdata;

            if (a_gnt)      owner <= 1'b0;
            else if (b_gnt) owner <= 1'b1;

            case (state)
                IDLE: begin
                    lock_cnt <= '0;
                    if (a_gnt && a_lock)      state <= LOCK_A;
                    else if (b_gnt && b_lock) state <= LOCK_B;
                end
                LOCK_A: begin
                    // Forced release bounds how long B can be starved.
                    if (!a_lock || (lock_cnt == CNT_LAST && b_req)) begin
                        state    <= IDLE;
                        owner    <= 1'b0;
                        lock_cnt <= '0;
                    end else if (b_req) begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                LOCK_B: begin
                    if (!b_lock || (lock_cnt == CNT_LAST && a_req)) begin
                        state    <= IDLE;
                        owner    <= 1'b1;
                        lock_cnt <= '0;
                    end else if (a_req) begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    lock_cnt <= '0;
                end
            endcase
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_a_cnt        <= '0;
            stat_b_cnt        <= '0;
            stat_conflict_cnt <= '0;
        end else begin
            if (a_gnt && stat_a_cnt != 16'hFFFF) stat_a_cnt <= stat_a_cnt + 16'd1;
            if (b_gnt && stat_b_cnt != 16'hFFFF) stat_b_cnt <= stat_b_cnt + 16'd1;
            if (a_req && b_req && stat_conflict_cnt != 16'hFFFF)
                stat_conflict_cnt <= stat_conflict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word-addressed memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        a_req, a_we, a_lock, b_req, b_we, b_lock;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_gnt, b_gnt, a_rvalid, b_rvalid, mem_we, owner;
    logic [31:0] a_rdata, b_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_a_cnt, stat_b_cnt, stat_conflict_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [0:63];
    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [31:0] pre_dat;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_we)      mem[mem_addr[7:2]] <= mem_wdata;
        else if (pre_we) mem[pre_idx] <= pre_dat;
    end

    dmem_arbiter #(.DW(32), .AW(32), .LOCK_MAX(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_lock(a_lock),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .owner(owner)
`ifdef DMEM_ARB_STATS_EN
        , .stat_a_cnt(stat_a_cnt), .stat_b_cnt(stat_b_cnt), .stat_conflict_cnt(stat_conflict_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_req = 0; a_we = 0; a_lock = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_lock = 0; b_addr = 0; b_wdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 0;
        step();
        reset_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 0;
        pre_we = 1; pre_idx = 6'd4; pre_dat = 32'hDEADBEEF;
        step();
        pre_we = 0;
        a_req = 1; a_we = 1; b_req = 1; b_we = 1;
        #1;
        n_cmp++; if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin n_bad++; $display("FAIL reset_gnt a=%b b=%b want 0 0", a_gnt, b_gnt); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
        step();
        n_cmp++; if (owner !== 1'b1) begin n_bad++; $display("FAIL reset_owner got %b want 1", owner); end
        n_cmp++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid a=%b b=%b want 0 0", a_rvalid, b_rvalid); end
        n_cmp++; if (a_rdata !== 32'h0 || b_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata a=%h b=%h want 0 0", a_rdata, b_rdata); end
        idle_inputs();
        reset_n = 1;
    endtask

    task automatic test_uncontended_read();
        a_req = 1; a_we = 0; a_addr = 32'h10;
        #1;
        n_cmp++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin n_bad++; $display("FAIL rd_gnt a=%b b=%b want 1 0", a_gnt, b_gnt); end
        n_cmp++; if (mem_addr !== 32'h10 || mem_we !== 1'b0) begin n_bad++; $display("FAIL rd_mem addr=%h we=%b want 10 0", mem_addr, mem_we); end
        step();
        a_req = 0;
        n_cmp++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_data v=%b d=%h want 1 deadbeef", a_rvalid, a_rdata); end
        n_cmp++; if (b_rvalid !== 1'b0) begin n_bad++; $display("FAIL rd_b_rvalid got %b want 0", b_rvalid); end
        step();
        n_cmp++; if (a_rvalid !== 1'b0 || a_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_hold v=%b d=%h want 0 deadbeef", a_rvalid, a_rdata); end
    endtask

    task automatic test_contention();
        do_reset();
        a_req = 1; b_req = 1; a_addr = 32'h4; b_addr = 32'h8;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (a_gnt !== ((i % 2) == 0) || b_gnt !== ((i % 2) == 1)) begin
                n_bad++; $display("FAIL rr_gnt%0d a=%b b=%b want %b %b", i, a_gnt, b_gnt, (i % 2) == 0, (i % 2) == 1);
            end
            step();
            n_cmp++;
            if (owner !== ((i % 2) == 1)) begin n_bad++; $display("FAIL rr_owner%0d got %b want %b", i, owner, (i % 2) == 1); end
        end
        idle_inputs();
    endtask

    task automatic test_write_read();
        a_req = 1; a_we = 1; a_addr = 32'h20; a_wdata = 32'h12345678;
        #1;
        n_cmp++; if (a_gnt !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h12345678) begin
            n_bad++; $display("FAIL wr_mem gnt=%b we=%b wd=%h want 1 1 12345678", a_gnt, mem_we, mem_wdata);
        end
        step();
        idle_inputs();
        n_cmp++; if (a_rvalid !== 1'b0) begin n_bad++; $display("FAIL wr_no_rvalid got %b want 0", a_rvalid); end
        b_req = 1; b_we = 0; b_addr = 32'h20;
        #1;
        n_cmp++; if (b_gnt !== 1'b1 || mem_addr !== 32'h20) begin n_bad++; $display("FAIL rb_gnt gnt=%b addr=%h want 1 20", b_gnt, mem_addr); end
        step();
        b_req = 0;
        n_cmp++; if (b_rvalid !== 1'b1 || b_rdata !== 32'h12345678) begin n_bad++; $display("FAIL rb_data v=%b d=%h want 1 12345678", b_rvalid, b_rdata); end
    endtask

    task automatic test_lock_release();
        // owner is B here, so A takes the first tie and locks.
        a_req = 1; a_lock = 1; a_addr = 32'h30; b_req = 1; b_addr = 32'h34;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin n_bad++; $display("FAIL lock_gnt%0d a=%b b=%b want 1 0", i, a_gnt, b_gnt); end
            step();
        end
        a_lock = 0;
        #1;
        n_cmp++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin n_bad++; $display("FAIL unlock_last a=%b b=%b want 1 0", a_gnt, b_gnt); end
        step();
        #1;
        n_cmp++; if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin n_bad++; $display("FAIL unlock_b a=%b b=%b want 0 1", a_gnt, b_gnt); end
        step();
        idle_inputs();
        // Locked port idle: nothing granted and no write strobe.
        a_req = 1; a_lock = 1; a_we = 1;
        step();
        a_req = 0;
        #1;
        n_cmp++; if (a_gnt !== 1'b0 || mem_we !== 1'b0) begin n_bad++; $display("FAIL lock_idle gnt=%b we=%b want 0 0", a_gnt, mem_we); end
        b_req = 1;
        #1;
        n_cmp++; if (b_gnt !== 1'b0) begin n_bad++; $display("FAIL lock_idle_b got %b want 0", b_gnt); end
        idle_inputs();
        step();
    endtask

    task automatic test_forced_release();
        do_reset();
        a_req = 1; a_lock = 1; b_req = 1;
        // One IDLE grant plus 8 locked cycles, then B is forced in.
        for (int i = 0; i < 9; i++) begin
            #1;
            n_cmp++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin n_bad++; $display("FAIL force_hold%0d a=%b b=%b want 1 0", i, a_gnt, b_gnt); end
            step();
        end
        #1;
        n_cmp++; if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin n_bad++; $display("FAIL force_b a=%b b=%b want 0 1", a_gnt, b_gnt); end
        step();
        n_cmp++; if (owner !== 1'b1) begin n_bad++; $display("FAIL force_owner got %b want 1", owner); end
        #1;
        n_cmp++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin n_bad++; $display("FAIL force_next_tie a=%b b=%b want 1 0", a_gnt, b_gnt); end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_reset_midlock();
        do_reset();
        b_req = 1; b_lock = 1; b_addr = 32'h10;
        step();
        a_req = 1;
        #1;
        n_cmp++; if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin n_bad++; $display("FAIL lockb_gnt a=%b b=%b want 0 1", a_gnt, b_gnt); end
        step();
        n_cmp++; if (b_rvalid !== 1'b1) begin n_bad++; $display("FAIL lockb_rvalid got %b want 1", b_rvalid); end
        reset_n = 0;
        #1;
        n_cmp++; if (b_gnt !== 1'b0 || a_gnt !== 1'b0) begin n_bad++; $display("FAIL midrst_gnt a=%b b=%b want 0 0", a_gnt, b_gnt); end
        step();
        n_cmp++; if (b_rvalid !== 1'b0 || b_rdata !== 32'h0 || owner !== 1'b1) begin
            n_bad++; $display("FAIL midrst_state v=%b d=%h own=%b want 0 0 1", b_rvalid, b_rdata, owner);
        end
        reset_n = 1; b_lock = 0;
        #1;
        n_cmp++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin n_bad++; $display("FAIL midrst_tie a=%b b=%b want 1 0", a_gnt, b_gnt); end
        step();
        idle_inputs();
    endtask

    initial begin
        pre_we = 0; pre_idx = 0; pre_dat = 0;
        reset_n = 0;
        idle_inputs();
        step();
        test_reset();
        test_uncontended_read();
        test_contention();
        test_write_read();
        test_lock_release();
        test_forced_release();
        test_reset_midlock();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter sharing the single-port data memory between the CPU data path (port A) and a loader/debug master (port B).
- Grants one access per cycle and drives the memory's write-enable, address and write-data lines. Registers read data back to the winning port.
- Round-robin on contention, plus a bounded lock so a master can hold the memory for an atomic sequence.
- Sits between the requesters and the data memory, which has a combinational read and a write at posedge.

Parameters:
- DW, 32, data width of the write-data and read-data buses.
- AW, 32, address width (byte address, passed through unchanged; the memory does the word indexing).
- LOCK_MAX, 8, maximum consecutive locked cycles a port may hold while the other port is requesting; must be ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- a_req, b_req  in  1  access request, held until granted.
- a_we, b_we  in  1  1=write, 0=read.
- a_addr, b_addr  in  AW  byte address.
- a_wdata, b_wdata  in  DW  write data.
- a_lock, b_lock  in  1  request to keep the grant on following cycles.
- a_gnt, b_gnt  out  1  combinational grant; the access completes at this posedge.
- a_rvalid, b_rvalid  out  1  registered; read data valid, one cycle after a granted read.
- a_rdata, b_rdata  out  DW  registered read data, held until the next read on that port.
- mem_we  out  1  to the memory write-enable.
- mem_addr  out  AW  to the memory address.
- mem_wdata  out  DW  to the memory write data.
- mem_rdata  in  DW  from the memory read data.
- owner  out  1  registered; last granted port (0=A, 1=B).

Behaviour:
- Reset (reset_n=0 at posedge):
  - State IDLE, lock_cnt=0, owner=1 (so A wins the first tie).
  - a_rvalid=b_rvalid=0, a_rdata=b_rdata=0.
  - While reset_n=0, a_gnt=b_gnt=0 and mem_we=0 combinationally.
- Grant is combinational, with at most one of a_gnt/b_gnt high.
- Memory signals:
  - mem_addr and mem_wdata mux from the granted port; default port A fields when neither is granted.
  - mem_we = granted port's we; 0 when no grant.
- Handshake: an access is transferred when x_req & x_gnt at a posedge. An uncontended request is granted in the same cycle (zero wait).
- Read return:
  - A granted read captures mem_rdata into x_rdata at that posedge and sets x_rvalid=1 for exactly one cycle.
  - A granted write sets no rvalid. Back-to-back reads produce rvalid on consecutive cycles.
- FSM states:
  - IDLE:
    - Only one request pending: grant it.
    - Both pending: grant the port ≠ owner.
    - On a grant with x_lock=1, go to LOCK_X with lock_cnt=0.
  - LOCK_A / LOCK_B:
    - The other port is never granted.
    - The locked port is granted whenever it requests.
    - lock_cnt increments each cycle the other port is requesting and holds otherwise.
  - Exit LOCK_X to IDLE when x_lock=0 at a posedge, or when lock_cnt=LOCK_MAX-1 and the other port is requesting (forced release).
  - On exit owner=X, so the other port wins the next tie.
  - Locked port idle (x_req=0) with x_lock=1: the memory stays reserved and mem_we=0.
- owner updates at every posedge with a grant.
- Reset mid-lock or mid-read returns to IDLE; pending rvalid is dropped (0 next cycle).
- No buffering: a request not granted stays pending; the requester holds its fields stable.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- Defined: adds outputs stat_a_cnt, stat_b_cnt and stat_conflict_cnt, each 16 bits.
  - stat_a_cnt and stat_b_cnt count grants per port.
  - stat_conflict_cnt counts cycles with both requests pending.
  - All saturate at 16'hFFFF and clear on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Uncontended read: memory word at 0x10 preloaded with 0xDEADBEEF; a_req=1, a_we=0, a_addr=0x10 → a_gnt=1 that cycle; next cycle a_rvalid=1, a_rdata=0xDEADBEEF; b_rvalid stays 0.
- Contention after reset: a_req=b_req=1 held for 4 cycles → grants A,B,A,B; owner after each grant = 0,1,0,1.
- Write then read across ports: A writes 0x12345678 to 0x20; B then reads 0x20 → b_rdata=0x12345678, with b_rvalid one cycle after b_gnt.
- Lock and release: A granted with a_lock=1 for 3 cycles while b_req=1 → b_gnt=0 throughout; a_lock drops → B granted next cycle.
- Forced release: LOCK_MAX=8, A holds a_lock=1 indefinitely, b_req=1 → B granted on the cycle after 8 locked cycles; the next tie is granted to B's opposite per owner.
- Reset mid-lock: reset_n=0 for 1 cycle during LOCK_B with a read granted → rvalid 0, state IDLE, first tie afterwards granted to A.
